// File: rtl/branch_resolve_update.sv
// Execute-stage branch resolve: registered one-cycle flush/redirect on mispredict, BTB updates
// queued in a small FIFO (dropped when full and not draining); BRU_STATS_EN adds event counters.
module branch_resolve_update #(
   parameter int DATA_WIDTH = 32,
   parameter int BTB_ROWS   = 16,
   parameter int UPD_DEPTH  = 2,
   localparam int IDX_W     = $clog2(BTB_ROWS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  br_valid_e,
   input  logic                  br_type_e,
   input  logic [DATA_WIDTH-1:0] PC_e,
   input  logic [DATA_WIDTH-1:0] target_e,
   input  logic                  taken_e,
   input  logic                  pred_hit_e,
   input  logic                  pred_taken_e,
   input  logic [DATA_WIDTH-1:0] pred_target_e,
   input  logic [1:0]            pred_ctr_e,
   output logic                  flush,
   output logic [DATA_WIDTH-1:0] redirect_PC,
   output logic                  btb_wr_valid,
   input  logic                  btb_wr_ready,
   output logic [IDX_W-1:0]      btb_wr_idx,
   output logic [DATA_WIDTH-1:0] btb_wr_tag,
   output logic [DATA_WIDTH-1:0] btb_wr_target,
   output logic [1:0]            btb_wr_pred,
   output logic                  btb_wr_type
`ifdef BRU_STATS_EN
   ,
   output logic [31:0]           stat_branches,
   output logic [31:0]           stat_mispred,
   output logic [31:0]           stat_dropped
`endif
);

   localparam int PTR_W = $clog2(UPD_DEPTH);
   localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(UPD_DEPTH);

   typedef struct packed {
      logic [IDX_W-1:0]      idx;
      logic [DATA_WIDTH-1:0] tag;
      logic [DATA_WIDTH-1:0] target;
      logic [1:0]            pred;
      logic                  typ;
   } upd_t;

   logic                  flush_q, flush_d;
   logic [DATA_WIDTH-1:0] redirect_q, redirect_d;
   upd_t                  fifo_q [UPD_DEPTH];
   upd_t                  fifo_d [UPD_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]        cnt_q, cnt_d;
   logic                  accept, mispred, wr_req, full, pop, push, drop;
   upd_t                  new_upd, head;

   always_comb begin
      // Instr in execute while flush is high is wrong-path and must not train.
      accept  = br_valid_e && !flush_q;
      mispred = (taken_e != pred_taken_e) || (taken_e && (pred_target_e != target_e));

      wr_req         = 1'b0;
      new_upd        = '0;
      new_upd.idx    = PC_e[IDX_W+1:2];
      new_upd.tag    = PC_e;
      new_upd.target = target_e;
      new_upd.typ    = br_type_e;
      new_upd.pred   = 2'b11;
      if (br_type_e) begin
         wr_req = 1'b1;
      end else if (pred_hit_e) begin
         wr_req = 1'b1;
         if (taken_e)
            new_upd.pred = (pred_ctr_e == 2'b11) ? 2'b11 : pred_ctr_e + 2'd1;
         else
            new_upd.pred = (pred_ctr_e == 2'b00) ? 2'b00 : pred_ctr_e - 2'd1;
      end else if (taken_e) begin
         wr_req       = 1'b1;
         new_upd.pred = 2'b10;
      end

      full = (cnt_q == DEPTH_C);
      pop  = (cnt_q != '0) && btb_wr_ready;
      push = accept && wr_req && (!full || pop);
      drop = accept && wr_req && full && !pop;

      flush_d    = accept && mispred;
      redirect_d = redirect_q;
      if (flush_d)
         redirect_d = taken_e ? target_e : PC_e + DATA_WIDTH'(4);

      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         fifo_d[wr_ptr_q] = new_upd;
         wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      if (pop)
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      cnt_d = cnt_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flush_q    <= 1'b0;
         redirect_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         for (int i = 0; i < UPD_DEPTH; i++)
            fifo_q[i] <= '0;
      end else begin
         flush_q    <= flush_d;
         redirect_q <= redirect_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         fifo_q     <= fifo_d;
      end
   end

   assign flush        = flush_q;
   assign redirect_PC  = redirect_q;
   assign head         = fifo_q[rd_ptr_q];
   assign btb_wr_valid = (cnt_q != '0);
   assign btb_wr_idx    = btb_wr_valid ? head.idx    : '0;
   assign btb_wr_tag    = btb_wr_valid ? head.tag    : '0;
   assign btb_wr_target = btb_wr_valid ? head.target : '0;
   assign btb_wr_pred   = btb_wr_valid ? head.pred   : '0;
   assign btb_wr_type   = btb_wr_valid ? head.typ    : 1'b0;

`ifdef BRU_STATS_EN
   logic [31:0] stat_br_q, stat_br_d, stat_mis_q, stat_mis_d, stat_drop_q, stat_drop_d;

   always_comb begin
      stat_br_d   = (accept && stat_br_q != '1) ? stat_br_q + 32'd1 : stat_br_q;
      stat_mis_d  = (flush_d && stat_mis_q != '1) ? stat_mis_q + 32'd1 : stat_mis_q;
      stat_drop_d = (drop && stat_drop_q != '1) ? stat_drop_q + 32'd1 : stat_drop_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_br_q   <= '0;
         stat_mis_q  <= '0;
         stat_drop_q <= '0;
      end else begin
         stat_br_q   <= stat_br_d;
         stat_mis_q  <= stat_mis_d;
         stat_drop_q <= stat_drop_d;
      end
   end

   assign stat_branches = stat_br_q;
   assign stat_mispred  = stat_mis_q;
   assign stat_dropped  = stat_drop_q;
`endif

endmodule
